fifo_wr_arb: RTL

//  Two-requester round-robin write arbiter in front of the 16-deep, 8-bit fifo buffer.

---
 rtl/fifo_wr_arb_if.sv | 30 +++
 rtl/fifo_wr_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb_if.sv
// Bundle of requester, fifo-write and status signals around the two-port fifo write arbiter.
// The master side drives requests and the fifo full flag; the slave side is the arbiter.
interface fifo_wr_arb_if #(
    parameter int DATA_W = 8
);
    logic              req0;
    logic [DATA_W-1:0] data0;
    logic              last0;
    logic              ack0;
    logic              req1;
    logic [DATA_W-1:0] data1;
    logic              last1;
    logic              ack1;
    logic              fifo_full;
    logic              fifo_write_en;
    logic [DATA_W-1:0] fifo_data;
    logic [1:0]        grant;
    logic [15:0]       cnt0;
    logic [15:0]       cnt1;

    modport master (
        output req0, data0, last0, req1, data1, last1, fifo_full,
        input  ack0, ack1, fifo_write_en, fifo_data, grant, cnt0, cnt1
    );

    modport slave (
        input  req0, data0, last0, req1, data1, last1, fifo_full,
        output ack0, ack1, fifo_write_en, fifo_data, grant, cnt0, cnt1
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Two-requester round-robin write arbiter feeding a fifo write port, with a burst-length cap.
// Define FIFO_ARB_CNT_EN to build the saturating per-requester beat counters cnt0/cnt1.
module fifo_wr_arb #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fifo_wr_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [3:0]        beat_q, beat_d;
    logic              ack0_s, ack1_s;
    logic [DATA_W-1:0] fifo_data_s;

    // State, priority pointer and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            beat_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state and beat-transfer decode; a stalled beat never releases the grant.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        ack0_s      = 1'b0;
        ack1_s      = 1'b0;
        fifo_data_s = '0;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_d = ptr_q ? G1 : G0;
                end else if (bus.req0) begin
                    state_d = G0;
                end else if (bus.req1) begin
                    state_d = G1;
                end else begin
                    state_d = IDLE;
                end
            end
            G0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? G1 : IDLE;
                    ptr_d   = 1'b1;
                    beat_d  = 4'd0;
                end else if (!bus.fifo_full) begin
                    ack0_s      = 1'b1;
                    fifo_data_s = bus.data0;
                    if (bus.last0 || (beat_q == BURST_LAST)) begin
                        state_d = bus.req1 ? G1 : IDLE;
                        ptr_d   = 1'b1;
                        beat_d  = 4'd0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end else begin
                    state_d = G0;
                end
            end
            G1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? G0 : IDLE;
                    ptr_d   = 1'b0;
                    beat_d  = 4'd0;
                end else if (!bus.fifo_full) begin
                    ack1_s      = 1'b1;
                    fifo_data_s = bus.data1;
                    if (bus.last1 || (beat_q == BURST_LAST)) begin
                        state_d = bus.req0 ? G0 : IDLE;
                        ptr_d   = 1'b0;
                        beat_d  = 4'd0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end else begin
                    state_d = G1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = 1'b0;
                beat_d  = 4'd0;
            end
        endcase
    end

    assign bus.ack0          = ack0_s;
    assign bus.ack1          = ack1_s;
    assign bus.fifo_write_en = ack0_s | ack1_s;
    assign bus.fifo_data     = fifo_data_s;
    assign bus.grant         = state_q;

`ifdef FIFO_ARB_CNT_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Saturating accepted-beat counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else begin
            if (ack0_s && (cnt0_q != 16'hFFFF)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (ack1_s && (cnt1_q != 16'hFFFF)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;
`else
    assign bus.cnt0 = 16'h0000;
    assign bus.cnt1 = 16'h0000;
`endif

endmodule
